// File: rtl/verifier_eval_mle_fold_pkg.sv
`default_nettype none
// ============================================================================
// Package : verifier_eval_mle_fold_pkg
// Purpose : Prime-field constants and the product reduction helper shared by
//           the MLE fold datapath. The field is GF(q), q = 2^31 - 1, and every
//           element is carried in F_NBITS = 32 bits with value < q.
// Contents: F_NBITS, FIELD_Q, field_reduce_prod()
// Revision: 1.0 - initial release
// ============================================================================
package verifier_eval_mle_fold_pkg;

  localparam int                 F_NBITS = 32;
  localparam logic [F_NBITS-1:0] FIELD_Q = 32'h7FFF_FFFF;

  // Reduce a double-width product mod 2^31-1. Because 2^31 == 1 (mod q),
  // the 31-bit digits of the product can simply be summed; two folds and a
  // single conditional subtract leave a canonical value.
  function automatic logic [F_NBITS-1:0] field_reduce_prod(
    input logic [2*F_NBITS-1:0] prod
  );
    logic [32:0]        s1;
    logic [F_NBITS-1:0] s2;
    s1 = 33'(prod[30:0]) + 33'(prod[61:31]) + 33'(prod[63:62]);
    s2 = 32'(s1[30:0]) + 32'(s1[32:31]);
    return (s2 >= FIELD_Q) ? (s2 - FIELD_Q) : s2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/field_adder.sv
`default_nettype none
// ============================================================================
// Module  : field_adder
// Purpose : c = (a + b) mod q, registered. ready pulses for one cycle, the
//           cycle after en, while c holds the new sum.
// Ports   : clk, rstb (async, active-low), en, a, b -> c, ready
// Revision: 1.0 - initial release
// ============================================================================
module field_adder
  import verifier_eval_mle_fold_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] c,
  output logic               ready
);

  logic [F_NBITS-1:0] sum;
  logic [F_NBITS-1:0] sum_red;

  always_comb begin
    sum     = a + b;
    sum_red = (sum >= FIELD_Q) ? (sum - FIELD_Q) : sum;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      c     <= '0;
      ready <= 1'b0;
    end else begin
      ready <= en;
      if (en) c <= sum_red;
    end
  end

endmodule
`default_nettype wire

// File: rtl/field_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : field_multiplier
// Purpose : c = (a * b) mod q in two stages: raw product, then reduction.
//           ready pulses for one cycle, two cycles after en.
// Ports   : clk, rstb (async, active-low), en, a, b -> c, ready
// Revision: 1.0 - initial release
// ============================================================================
module field_multiplier
  import verifier_eval_mle_fold_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] c,
  output logic               ready
);

  logic [2*F_NBITS-1:0] prod;
  logic                 prod_vld;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      c        <= '0;
      ready    <= 1'b0;
    end else begin
      prod_vld <= en;
      ready    <= prod_vld;
      if (en)       prod <= 64'(a) * 64'(b);
      if (prod_vld) c    <= field_reduce_prod(prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/field_subtract.sv
`default_nettype none
// ============================================================================
// Module  : field_subtract
// Purpose : c = (a - b) mod q, registered. ready pulses for one cycle, the
//           cycle after en, while c holds the new difference.
// Ports   : clk, rstb (async, active-low), en, a, b -> c, ready
// Revision: 1.0 - initial release
// ============================================================================
module field_subtract
  import verifier_eval_mle_fold_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] c,
  output logic               ready
);

  logic [F_NBITS-1:0] diff;

  // a + (q - b) stays below 2q, so it cannot overflow the 32-bit carrier.
  always_comb diff = (a >= b) ? (a - b) : (a + (FIELD_Q - b));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      c     <= '0;
      ready <= 1'b0;
    end else begin
      ready <= en;
      if (en) c <= diff;
    end
  end

endmodule
`default_nettype wire

// File: rtl/verifier_mle_fold_step.sv
`default_nettype none
// ============================================================================
// Module  : verifier_mle_fold_step
// Purpose : One fold step y = a + t*(b - a) mod q, built as a subtract ->
//           multiply -> add chain. The caller sequences the three units by
//           pulsing each en and waiting for the matching ready; a, b and t
//           must stay stable until add_ready.
// Ports   : clk, rstb, sub_en/mul_en/add_en, a, b, t
//           -> sub_ready/mul_ready/add_ready, y (valid with add_ready)
// Revision: 1.0 - initial release
// ============================================================================
module verifier_mle_fold_step
  import verifier_eval_mle_fold_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               sub_en,
  input  logic               mul_en,
  input  logic               add_en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  input  logic [F_NBITS-1:0] t,
  output logic               sub_ready,
  output logic               mul_ready,
  output logic               add_ready,
  output logic [F_NBITS-1:0] y
);

  logic [F_NBITS-1:0] d;
  logic [F_NBITS-1:0] p;

  field_subtract u_sub (
    .clk   (clk),
    .rstb  (rstb),
    .en    (sub_en),
    .a     (b),
    .b     (a),
    .c     (d),
    .ready (sub_ready)
  );

  field_multiplier u_mul (
    .clk   (clk),
    .rstb  (rstb),
    .en    (mul_en),
    .a     (t),
    .b     (d),
    .c     (p),
    .ready (mul_ready)
  );

  field_adder u_add (
    .clk   (clk),
    .rstb  (rstb),
    .en    (add_en),
    .a     (a),
    .b     (p),
    .c     (y),
    .ready (add_ready)
  );

endmodule
`default_nettype wire

// File: rtl/verifier_eval_mle_fold.sv
`default_nettype none
// ============================================================================
// Module  : verifier_eval_mle_fold
// Purpose : Evaluates the multilinear extension of a 2^nValBits-entry vector
//           at point tau by folding the vector in place, one variable per
//           round: v[i] <= v[2i] + tau[j]*(v[2i+1] - v[2i]).
// Ports   : clk, rstb (async, active-low)
//           en      - rising edge starts an evaluation (ignored while busy)
//           tau     - evaluation point, tau[j] binds index bit j
//           vals_in - vector to fold, sampled on the start cycle only
//           result  - MLE value, held from one completion to the next
//           ready   - idle and no start pending
// Revision: 1.0 - initial release
// ============================================================================
module verifier_eval_mle_fold
  import verifier_eval_mle_fold_pkg::*;
#(
  parameter int nValBits = 3,
  parameter int nValues  = 1 << nValBits
)(
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              en,
  input  logic [nValBits-1:0][F_NBITS-1:0]  tau,
  input  logic [nValues-1:0][F_NBITS-1:0]   vals_in,
  output logic [F_NBITS-1:0]                result,
  output logic                              ready
);

  localparam int RND_W  = $clog2(nValBits + 1);
  localparam int PAIR_W = (nValBits > 1) ? (nValBits - 1) : 1;

  if (nValBits < 1) begin : g_bad_nvalbits
    $error("verifier_eval_mle_fold: nValBits must be >= 1");
  end
  if (nValues != (1 << nValBits)) begin : g_bad_nvalues
    $error("verifier_eval_mle_fold: nValues is derived and must equal 1<<nValBits");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SUB_ST = 3'd1,
    ST_SUB    = 3'd2,
    ST_MUL_ST = 3'd3,
    ST_MUL    = 3'd4,
    ST_ADD_ST = 3'd5,
    ST_ADD    = 3'd6
  } state_t;

  state_t                           state;
  state_t                           state_nxt;
  logic                             en_dly;
  logic                             start;
  logic [RND_W-1:0]                 round;
  logic [PAIR_W-1:0]                pair;
  logic [F_NBITS-1:0]               v [nValues];
  logic [nValBits-1:0][F_NBITS-1:0] tau_q;

  logic [nValBits-1:0] wr_idx;
  logic [nValBits-1:0] idx_a;
  logic [nValBits-1:0] idx_b;
  logic [F_NBITS-1:0]  t_sel;
  logic                last_pair;
  logic                last_round;

  logic               sub_en;
  logic               mul_en;
  logic               add_en;
  logic               sub_ready;
  logic               mul_ready;
  logic               add_ready;
  logic [F_NBITS-1:0] step_y;

  // en_dly resets high so an en already asserted at reset release is not
  // mistaken for a rising edge.
  assign start = en & ~en_dly;

  // Pair i reads v[2i], v[2i+1] and writes v[i]; since i <= 2i, a write never
  // lands on an entry still to be read in the current round.
  assign wr_idx = nValBits'(pair);
  assign idx_a  = wr_idx << 1;
  assign idx_b  = idx_a | nValBits'(1);

  always_comb begin
    t_sel = '0;
    for (int j = 0; j < nValBits; j++) begin
      if (int'(round) == j) t_sel = tau_q[j];
    end
  end

  assign last_round = (int'(round) == (nValBits - 1));
  assign last_pair  = (int'(pair) == ((nValues >> (int'(round) + 1)) - 1));

  verifier_mle_fold_step u_step (
    .clk       (clk),
    .rstb      (rstb),
    .sub_en    (sub_en),
    .mul_en    (mul_en),
    .add_en    (add_en),
    .a         (v[idx_a]),
    .b         (v[idx_b]),
    .t         (t_sel),
    .sub_ready (sub_ready),
    .mul_ready (mul_ready),
    .add_ready (add_ready),
    .y         (step_y)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sub_en    = 1'b0;
    mul_en    = 1'b0;
    add_en    = 1'b0;
    ready     = (state == ST_IDLE) && !start;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SUB_ST;
      ST_SUB_ST: begin
        sub_en    = 1'b1;
        state_nxt = ST_SUB;
      end
      ST_SUB:    if (sub_ready) state_nxt = ST_MUL_ST;
      ST_MUL_ST: begin
        mul_en    = 1'b1;
        state_nxt = ST_MUL;
      end
      ST_MUL:    if (mul_ready) state_nxt = ST_ADD_ST;
      ST_ADD_ST: begin
        add_en    = 1'b1;
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        if (add_ready) state_nxt = (last_pair && last_round) ? ST_IDLE : ST_SUB_ST;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      en_dly <= 1'b1;
      round  <= '0;
      pair   <= '0;
      result <= '0;
      tau_q  <= '0;
      for (int i = 0; i < nValues; i++) v[i] <= '0;
    end else begin
      en_dly <= en;
      if ((state == ST_IDLE) && start) begin
        for (int i = 0; i < nValues; i++) v[i] <= vals_in[i];
        tau_q <= tau;
        round <= '0;
        pair  <= '0;
      end else if ((state == ST_ADD) && add_ready) begin
        v[wr_idx] <= step_y;
        if (!last_pair) begin
          pair <= pair + PAIR_W'(1);
        end else if (!last_round) begin
          round <= round + RND_W'(1);
          pair  <= '0;
        end else begin
          result <= step_y;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_verifier_eval_mle_fold.sv
`default_nettype none
// ============================================================================
// Module  : tb_verifier_eval_mle_fold
// Purpose : Self-checking bench for verifier_eval_mle_fold at nValBits = 1, 2
//           and 3. Directed table vectors, a chi-expansion reference model for
//           random points, start-handshake and mid-run reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_verifier_eval_mle_fold;

  localparam logic [63:0] Q = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic              en1, en2, en3;
  logic [0:0][31:0]  tau1;
  logic [1:0][31:0]  tau2;
  logic [2:0][31:0]  tau3;
  logic [1:0][31:0]  vals1;
  logic [3:0][31:0]  vals2;
  logic [7:0][31:0]  vals3;
  logic [31:0]       res1, res2, res3;
  logic              rdy1, rdy2, rdy3;

  verifier_eval_mle_fold #(.nValBits(1)) dut1 (
    .clk(clk), .rstb(rstb), .en(en1), .tau(tau1), .vals_in(vals1),
    .result(res1), .ready(rdy1));
  verifier_eval_mle_fold #(.nValBits(2)) dut2 (
    .clk(clk), .rstb(rstb), .en(en2), .tau(tau2), .vals_in(vals2),
    .result(res2), .ready(rdy2));
  verifier_eval_mle_fold #(.nValBits(3)) dut3 (
    .clk(clk), .rstb(rstb), .en(en3), .tau(tau3), .vals_in(vals3),
    .result(res3), .ready(rdy3));

  int n_checks = 0;
  int n_fail   = 0;

  // Unit-enable and completed-pair counters for dut2.
  int cnt_en    = 0;
  int cnt_pairs = 0;
  always @(posedge clk) begin
    cnt_en    <= cnt_en + int'(dut2.sub_en) + int'(dut2.mul_en) + int'(dut2.add_en);
    cnt_pairs <= cnt_pairs + int'(dut2.add_ready);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = ({32'b0, a} + {32'b0, b}) % Q;
    return r[31:0];
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = ({32'b0, a} + Q - {32'b0, b}) % Q;
    return r[31:0];
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = ({32'b0, a} * {32'b0, b}) % Q;
    return r[31:0];
  endfunction

  // Reference: sum_i chi_i(t) * v[i], chi_i = prod_j (bit j of i ? t_j : 1 - t_j)
  function automatic logic [31:0] mle3(input logic [2:0][31:0] t, input logic [7:0][31:0] v);
    logic [31:0] acc, chi;
    acc = 32'd0;
    for (int i = 0; i < 8; i++) begin
      chi = 32'd1;
      for (int j = 0; j < 3; j++)
        chi = fmul(chi, (((i >> j) & 1) == 1) ? t[j] : fsub(32'd1, t[j]));
      acc = fadd(acc, fmul(chi, v[i]));
    end
    return acc;
  endfunction

  task automatic run1(input logic [0:0][31:0] t, input logic [1:0][31:0] v);
    bit ok;
    tau1 = t; vals1 = v; en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0; tau1 = '0; vals1 = '0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rdy1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("run1_timeout", 64'(ok), 64'd1);
  endtask

  task automatic run2(input logic [1:0][31:0] t, input logic [3:0][31:0] v);
    bit ok;
    tau2 = t; vals2 = v; en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0; tau2 = '0; vals2 = '0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (rdy2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("run2_timeout", 64'(ok), 64'd1);
  endtask

  task automatic run3(input logic [2:0][31:0] t, input logic [7:0][31:0] v);
    bit ok;
    tau3 = t; vals3 = v; en3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0; tau3 = '0; vals3 = '0;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (rdy3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("run3_timeout", 64'(ok), 64'd1);
  endtask

  typedef struct {
    string            name;
    logic [1:0][31:0] tau;
    logic [3:0][31:0] vals;
    logic [31:0]      exp;
  } vec2_t;

  vec2_t tbl [6];

  initial begin
    logic [2:0][31:0] tr;
    logic [7:0][31:0] vr;
    logic [1:0][31:0] t2;
    logic [3:0][31:0] v2;
    logic [0:0][31:0] t1;
    logic [1:0][31:0] v1;
    int               e0, p0;
    bit               ok;

    for (int i = 0; i < 6; i++) begin
      tbl[i].vals[0] = 32'd1; tbl[i].vals[1] = 32'd2;
      tbl[i].vals[2] = 32'd3; tbl[i].vals[3] = 32'd4;
    end
    tbl[0].name = "corner_00";  tbl[0].tau[0] = 32'd0; tbl[0].tau[1] = 32'd0; tbl[0].exp = 32'd1;
    tbl[1].name = "corner_10";  tbl[1].tau[0] = 32'd1; tbl[1].tau[1] = 32'd0; tbl[1].exp = 32'd2;
    tbl[2].name = "corner_01";  tbl[2].tau[0] = 32'd0; tbl[2].tau[1] = 32'd1; tbl[2].exp = 32'd3;
    tbl[3].name = "corner_11";  tbl[3].tau[0] = 32'd1; tbl[3].tau[1] = 32'd1; tbl[3].exp = 32'd4;
    tbl[4].name = "point_2_3";  tbl[4].tau[0] = 32'd2; tbl[4].tau[1] = 32'd3; tbl[4].exp = 32'd9;
    // v = {0, q-1, 0, 0}, tau = {2, 0}: 2*(q-1) mod q = q-2
    tbl[5].name = "wrap_qm1";   tbl[5].tau[0] = 32'd2; tbl[5].tau[1] = 32'd0; tbl[5].exp = 32'h7FFF_FFFD;
    tbl[5].vals[0] = 32'd0; tbl[5].vals[1] = 32'h7FFF_FFFE; tbl[5].vals[2] = 32'd0; tbl[5].vals[3] = 32'd0;

    // Reset with en2 held high: the release must not look like a rising edge.
    rstb = 1'b0;
    en1 = 1'b0; en2 = 1'b1; en3 = 1'b0;
    tau1 = '0; tau2 = '0; tau3 = '0; vals1 = '0; vals2 = '0; vals3 = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    e0 = cnt_en;
    repeat (5) @(negedge clk);
    check("reset_result1", 64'(res1), 64'd0);
    check("reset_result2", 64'(res2), 64'd0);
    check("reset_result3", 64'(res3), 64'd0);
    check("reset_ready1",  64'(rdy1), 64'd1);
    check("reset_ready2_en_high", 64'(rdy2), 64'd1);
    check("reset_no_start_en", 64'(cnt_en - e0), 64'd0);
    en2 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run2(tbl[i].tau, tbl[i].vals);
      check(tbl[i].name, 64'(res2), 64'(tbl[i].exp));
    end

    // Unit-enable and pair-op accounting for one nValBits=2 run.
    e0 = cnt_en; p0 = cnt_pairs;
    run2(tbl[4].tau, tbl[4].vals);
    check("count_result", 64'(res2), 64'd9);
    check("count_unit_enables", 64'(cnt_en - e0), 64'd9);
    check("count_pair_ops", 64'(cnt_pairs - p0), 64'd3);

    // nValBits=1, negative difference wraps: 5 + 3*(0-5) = -10
    t1[0] = 32'd3; v1[0] = 32'd5; v1[1] = 32'd0;
    run1(t1, v1);
    check("nvb1_wrap", 64'(res1), 64'h7FFF_FFF5);

    for (int it = 0; it < 200; it++) begin
      for (int j = 0; j < 3; j++) tr[j] = $urandom_range(32'h7FFF_FFFE, 0);
      for (int i = 0; i < 8; i++) vr[i] = $urandom_range(32'h7FFF_FFFE, 0);
      run3(tr, vr);
      check($sformatf("rand3_%0d", it), 64'(res3), 64'(mle3(tr, vr)));
    end

    // en held high across completion: exactly one run.
    t2[0] = 32'd2; t2[1] = 32'd3;
    v2[0] = 32'd1; v2[1] = 32'd2; v2[2] = 32'd3; v2[3] = 32'd4;
    e0 = cnt_en;
    tau2 = t2; vals2 = v2; en2 = 1'b1;
    @(negedge clk);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (rdy2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("held_done", 64'(ok), 64'd1);
    check("held_result", 64'(res2), 64'd9);
    repeat (20) @(negedge clk);
    check("held_still_ready", 64'(rdy2), 64'd1);
    check("held_one_run", 64'(cnt_en - e0), 64'd9);

    // Second rising edge while busy is ignored; result stays stale until done.
    en2 = 1'b0;
    @(negedge clk);
    v2[0] = 32'd10; v2[1] = 32'd20; v2[2] = 32'd30; v2[3] = 32'd40;
    t2[0] = 32'd1; t2[1] = 32'd1;
    e0 = cnt_en;
    tau2 = t2; vals2 = v2; en2 = 1'b1;
    repeat (3) @(negedge clk);
    en2 = 1'b0;
    @(negedge clk);
    en2 = 1'b1;
    @(negedge clk);
    check("busy_not_ready", 64'(rdy2), 64'd0);
    check("busy_result_stale", 64'(res2), 64'd9);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (rdy2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("busy_done", 64'(ok), 64'd1);
    check("busy_result_new", 64'(res2), 64'd40);
    repeat (20) @(negedge clk);
    check("busy_edge_ignored", 64'(cnt_en - e0), 64'd9);
    en2 = 1'b0;
    @(negedge clk);

    // Reset during round 1 of an nValBits=3 run.
    for (int j = 0; j < 3; j++) tr[j] = $urandom_range(32'h7FFF_FFFE, 1);
    for (int i = 0; i < 8; i++) vr[i] = $urandom_range(32'h7FFF_FFFE, 1);
    tau3 = tr; vals3 = vr; en3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (dut3.round == 2'd1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_reach_round1", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check("rst_result_zero", 64'(res3), 64'd0);
    check("rst_ready", 64'(rdy3), 64'd1);
    check("rst_round_zero", 64'(dut3.round), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    run3(tr, vr);
    check("rst_rerun", 64'(res3), 64'(mle3(tr, vr)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/verifier_eval_mle_fold.md
Name: verifier_eval_mle_fold

Overview:
Evaluates the multilinear extension of a 2^nValBits-entry value vector at point tau by successive in-place folding. Result equals sum_i chi_i(tau)*vals_in[i], the inner product against the basis vector that verifier_compute_chi_single expands, computed without materialising chi. Used on the verifier side to evaluate the input or output layer MLE at a sumcheck-derived point. One sequential field datapath: subtract, then multiply, then add.

Parameters:
nValBits, 3, number of variables / fold rounds; must be >= 1.
nValues, 1<<nValBits, vector length; derived, must not be overridden (error module on mismatch).

Ports:
clk  input  1  clock
rstb  input  1  reset, asynchronous, active-low
en  input  1  rising edge starts an evaluation
tau  input  [F_NBITS-1:0] x nValBits  evaluation point; tau[j] binds index bit j
vals_in  input  [F_NBITS-1:0] x nValues  values to fold
result  output  F_NBITS  MLE value at tau
ready  output  1  idle and no start pending

Behaviour:
- Start handshake: en_dly register, reset value 1; start = en & ~en_dly; ready = (state==ST_IDLE) & ~start. A start outside ST_IDLE is ignored. en held high starts exactly one run.
- On start, copy vals_in into storage v[0..nValues-1] and tau into tau_q. Inputs are don't-care after the start cycle.
- Rounds j = 0..nValBits-1. Pairs i = 0..(nValues>>(j+1))-1. Per pair:
  - d = v[2i+1] - v[2i]
  - p = tau_q[j]*d
  - v[i] <= v[2i] + p
  - All arithmetic is mod q, using field_subtract, field_multiplier and field_adder. Each unit is pulsed en for one cycle and waited on its ready.
- States:
  - ST_IDLE: on start, go to ST_SUB_ST with round=0, pair=0.
  - ST_SUB_ST/ST_SUB: when sub ready, go to ST_MUL_ST; otherwise stay in ST_SUB.
  - ST_MUL_ST/ST_MUL: when mul ready, go to ST_ADD_ST; otherwise stay in ST_MUL.
  - ST_ADD_ST/ST_ADD: when add ready, write v[pair] and advance:
    - Not last pair: pair+1, go to ST_SUB_ST.
    - Last pair, not last round: round+1, pair=0, go to ST_SUB_ST.
    - Last pair of last round: result <= adder output, go to ST_IDLE.
- The _ST state is the only cycle in which the unit's en is high. No other bubbles are allowed.
- Exactly nValues-1 pair operations per run, i.e. 3*(nValues-1) unit enables.
- Write-back to v[i] never corrupts unread data, because i <= 2i within a round.
- Reset values:
  - state ST_IDLE; round and pair 0; result 0; storage 0; en_dly 1; ready 1 once out of reset (en high during reset does not trigger a start).
- result is held from completion until the next completion. It is stale while busy. ready rises in the same cycle result updates.
- Reset mid-run: abort immediately to the reset values, no partial result. Field units are reset by the same rstb.
- nValBits=1: a single pair, then done.
- Widths: round counter $clog2(nValBits+1) bits; pair counter nValBits-1 bits (minimum 1).

Decomposition:
- F_NBITS, q and the field constants come from field_arith_defs.v. Nothing new goes into the shared package.
- The state enum stays local.
- One natural sub-module, verifier_mle_fold_step: the sub->mul->add chain with en/ready, inputs (a, b, t) and output a + t*(b - a). The top keeps only storage, counters and the FSM.

Test Plan:
- nValBits=2, vals={1,2,3,4}; tau={0,0}, {1,0}, {0,1}, {1,1} -> result 1, 2, 3, 4 respectively.
- nValBits=2, vals={1,2,3,4}, tau={2,3} -> result 9. Count unit enables = 9 and pair ops = 3.
- nValBits=1, vals={5,0}, tau={3} -> result q-10 (wrap on negative difference).
- nValBits=3, random vals and tau -> matches a bench model sum_i chi_i*vals[i] mod q computed via a chi expansion; 200 iterations.
- en held high across two runs and a second rising edge while busy -> exactly one run. The busy edge is ignored; result is unchanged until completion.
- Deassert rstb during round 1 -> state idle, result 0 immediately. A new start after release gives the correct value.
